// File: rtl/vm_pkg.sv
// Shared definitions for the vending payment path: coin encodings, coin
// values, controller states and the default credit width.
package vm_pkg;

  localparam int unsigned PRICE_W_DEF = 12;

  // Coin codes as carried on coin_type / change_coin
  localparam logic [1:0] COIN_5   = 2'b00;
  localparam logic [1:0] COIN_10  = 2'b01;
  localparam logic [1:0] COIN_25  = 2'b10;
  localparam logic [1:0] COIN_100 = 2'b11;

  // Coin values in cents
  localparam int unsigned VAL_5   = 5;
  localparam int unsigned VAL_10  = 10;
  localparam int unsigned VAL_25  = 25;
  localparam int unsigned VAL_100 = 100;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_CHANGE  = 2'd3
  } vm_state_t;

  // Value in cents of a coin code
  function automatic logic [6:0] coin_value(input logic [1:0] code);
    logic [6:0] v;
    case (code)
      COIN_5:  v = 7'(VAL_5);
      COIN_10: v = 7'(VAL_10);
      COIN_25: v = 7'(VAL_25);
      default: v = 7'(VAL_100);
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vm_change_picker.sv
// Greedy change selection: largest coin not exceeding the given amount.
module vm_change_picker
  import vm_pkg::*;
#(
  parameter int unsigned PRICE_W = PRICE_W_DEF
) (
  input  logic [PRICE_W-1:0] amount,
  output logic               have_coin,
  output logic [1:0]         coin_code,
  output logic [PRICE_W-1:0] coin_val
);

  // Pick the largest denomination that fits in amount
  always_comb begin
    have_coin = 1'b1;
    coin_code = COIN_5;
    coin_val  = PRICE_W'(VAL_5);
    if (amount >= PRICE_W'(VAL_100)) begin
      coin_code = COIN_100;
      coin_val  = PRICE_W'(VAL_100);
    end else if (amount >= PRICE_W'(VAL_25)) begin
      coin_code = COIN_25;
      coin_val  = PRICE_W'(VAL_25);
    end else if (amount >= PRICE_W'(VAL_10)) begin
      coin_code = COIN_10;
      coin_val  = PRICE_W'(VAL_10);
    end else if (amount >= PRICE_W'(VAL_5)) begin
      coin_code = COIN_5;
      coin_val  = PRICE_W'(VAL_5);
    end else begin
      have_coin = 1'b0;
      coin_code = '0;
      coin_val  = '0;
    end
  end

endmodule

// File: rtl/vm_payment_controller.sv
// Payment and vend control: latches a selection, collects coins until the
// price is covered, issues a one-cycle vend, then returns change greedily.
// Cancel and inactivity timeout refund the full credit.
module vm_payment_controller
  import vm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned PRICE_W        = PRICE_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               item_selection_valid,
  input  logic [3:0]         dispense_row,
  input  logic [3:0]         dispense_col,
  input  logic [PRICE_W-1:0] item_price,
  input  logic               coin_valid,
  input  logic [1:0]         coin_type,
  input  logic               cancel,
  output logic               busy,
  output logic [PRICE_W-1:0] credit,
  output logic               coin_reject,
  output logic               vend_valid,
  output logic [3:0]         vend_row,
  output logic [3:0]         vend_col,
  output logic               change_valid,
  output logic [1:0]         change_coin,
  output logic               change_done
);

  localparam int unsigned TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  vm_state_t            state_q, state_n;
  logic [3:0]           row_q, row_n;
  logic [3:0]           col_q, col_n;
  logic [PRICE_W-1:0]   price_q, price_n;
  logic [PRICE_W-1:0]   credit_n;
  logic [TIMER_W-1:0]   timer_q, timer_n;

  logic                 coin_reject_n;
  logic                 vend_valid_n;
  logic [3:0]           vend_row_n, vend_col_n;
  logic                 change_valid_n;
  logic [1:0]           change_coin_n;
  logic                 change_done_n;

  logic [PRICE_W:0]     coin_sum;
  logic                 coin_fits;
  logic                 coin_accept;
  logic [PRICE_W-1:0]   collect_credit;
  logic [PRICE_W-1:0]   change_src;

  logic                 pick_have;
  logic [1:0]           pick_code;
  logic [PRICE_W-1:0]   pick_val;

  assign coin_sum  = {1'b0, credit} + (PRICE_W+1)'(coin_value(coin_type));
  assign coin_fits = ~coin_sum[PRICE_W];

  // The first change coin (or change_done) is issued on the edge leaving VEND,
  // so the picker sees credit-price there and the running credit in CHANGE.
  assign change_src = (state_q == ST_VEND) ? (credit - price_q) : credit;

  vm_change_picker #(
    .PRICE_W (PRICE_W)
  ) u_change_picker (
    .amount    (change_src),
    .have_coin (pick_have),
    .coin_code (pick_code),
    .coin_val  (pick_val)
  );

  // Next-state and next-output computation
  always_comb begin
    state_n        = state_q;
    row_n          = row_q;
    col_n          = col_q;
    price_n        = price_q;
    credit_n       = credit;
    timer_n        = timer_q;
    coin_reject_n  = 1'b0;
    vend_valid_n   = 1'b0;
    vend_row_n     = '0;
    vend_col_n     = '0;
    change_valid_n = 1'b0;
    change_coin_n  = '0;
    change_done_n  = 1'b0;
    coin_accept    = 1'b0;
    collect_credit = credit;

    case (state_q)
      ST_IDLE: begin
        coin_reject_n = coin_valid;
        if (item_selection_valid) begin
          row_n    = dispense_row;
          col_n    = dispense_col;
          price_n  = item_price;
          credit_n = '0;
          timer_n  = '0;
          state_n  = ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        coin_accept   = coin_valid & coin_fits;
        coin_reject_n = coin_valid & ~coin_fits;
        if (coin_accept) begin
          collect_credit = coin_sum[PRICE_W-1:0];
          timer_n        = '0;
        end else begin
          timer_n = timer_q + TIMER_W'(1);
        end
        credit_n = collect_credit;
        // Cancel outranks reaching the price; an accepted coin outranks timeout
        if (cancel) begin
          state_n = ST_CHANGE;
        end else if (collect_credit >= price_q) begin
          state_n      = ST_VEND;
          vend_valid_n = 1'b1;
          vend_row_n   = row_q;
          vend_col_n   = col_q;
        end else if (!coin_accept && (timer_q == TIMER_LAST)) begin
          state_n = ST_CHANGE;
        end
      end

      ST_VEND, ST_CHANGE: begin
        coin_reject_n = coin_valid;
        if (pick_have) begin
          change_valid_n = 1'b1;
          change_coin_n  = pick_code;
          credit_n       = change_src - pick_val;
          state_n        = ST_CHANGE;
        end else begin
          change_done_n = 1'b1;
          credit_n      = '0;
          state_n       = ST_IDLE;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any transaction
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      price_q      <= '0;
      timer_q      <= '0;
      busy         <= 1'b0;
      credit       <= '0;
      coin_reject  <= 1'b0;
      vend_valid   <= 1'b0;
      vend_row     <= '0;
      vend_col     <= '0;
      change_valid <= 1'b0;
      change_coin  <= '0;
      change_done  <= 1'b0;
    end else begin
      state_q      <= state_n;
      row_q        <= row_n;
      col_q        <= col_n;
      price_q      <= price_n;
      timer_q      <= timer_n;
      busy         <= (state_n != ST_IDLE);
      credit       <= credit_n;
      coin_reject  <= coin_reject_n;
      vend_valid   <= vend_valid_n;
      vend_row     <= vend_row_n;
      vend_col     <= vend_col_n;
      change_valid <= change_valid_n;
      change_coin  <= change_coin_n;
      change_done  <= change_done_n;
    end
  end

endmodule

// File: tb/tb_vm_payment_controller.sv
// Directed bench for vm_payment_controller: a table of per-cycle vectors
// plus hand-built sequences for timeout and credit-overflow corners.
module tb_vm_payment_controller;

  localparam int unsigned PW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          item_selection_valid;
  logic [3:0]    dispense_row;
  logic [3:0]    dispense_col;
  logic [PW-1:0] item_price;
  logic          coin_valid;
  logic [1:0]    coin_type;
  logic          cancel;
  logic          busy;
  logic [PW-1:0] credit;
  logic          coin_reject;
  logic          vend_valid;
  logic [3:0]    vend_row;
  logic [3:0]    vend_col;
  logic          change_valid;
  logic [1:0]    change_coin;
  logic          change_done;

  vm_payment_controller #(
    .TIMEOUT_CYCLES (8),
    .PRICE_W        (PW)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .item_selection_valid (item_selection_valid),
    .dispense_row         (dispense_row),
    .dispense_col         (dispense_col),
    .item_price           (item_price),
    .coin_valid           (coin_valid),
    .coin_type            (coin_type),
    .cancel               (cancel),
    .busy                 (busy),
    .credit               (credit),
    .coin_reject          (coin_reject),
    .vend_valid           (vend_valid),
    .vend_row             (vend_row),
    .vend_col             (vend_col),
    .change_valid         (change_valid),
    .change_coin          (change_coin),
    .change_done          (change_done)
  );

  always #5 clk = ~clk;

  // {busy, credit, coin_reject, vend_valid, vend_row, vend_col, change_valid, change_coin, change_done}
  typedef logic [26:0] obs_t;

  typedef struct {
    string      name;
    logic       rst;
    logic       sel;
    logic [3:0] row;
    logic [3:0] col;
    logic [11:0] price;
    logic       cv;
    logic [1:0] ct;
    logic       can;
    obs_t       exp;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  function automatic obs_t ob(input logic b, input int cr, input logic rj, input logic vv,
                              input int vr, input int vc, input logic cvl, input int cc,
                              input logic dn);
    return {b, 12'(cr), rj, vv, 4'(vr), 4'(vc), cvl, 2'(cc), dn};
  endfunction

  function automatic vec_t mk(input string nm, input logic rst, input logic sel, input int r,
                              input int c, input int p, input logic cv, input int ct,
                              input logic can, input obs_t e);
    vec_t v;
    v.name = nm; v.rst = rst; v.sel = sel; v.row = 4'(r); v.col = 4'(c);
    v.price = 12'(p); v.cv = cv; v.ct = 2'(ct); v.can = can; v.exp = e;
    return v;
  endfunction

  // Inputs held for one clock; outputs compared 1 time unit after the edge
  task automatic apply(input vec_t v);
    obs_t act;
    reset = v.rst; item_selection_valid = v.sel; dispense_row = v.row;
    dispense_col = v.col; item_price = v.price; coin_valid = v.cv;
    coin_type = v.ct; cancel = v.can;
    @(posedge clk);
    #1;
    act = {busy, credit, coin_reject, vend_valid, vend_row, vend_col,
           change_valid, change_coin, change_done};
    checks++;
    if (act !== v.exp) begin
      errors++;
      $display("FAIL %s: got busy=%0b credit=%0d rej=%0b vv=%0b vr=%0d vc=%0d cv=%0b cc=%0d done=%0b, expected busy=%0b credit=%0d rej=%0b vv=%0b vr=%0d vc=%0d cv=%0b cc=%0d done=%0b",
               v.name, act[26], act[25:14], act[13], act[12], act[11:8], act[7:4], act[3], act[2:1], act[0],
               v.exp[26], v.exp[25:14], v.exp[13], v.exp[12], v.exp[11:8], v.exp[7:4], v.exp[3], v.exp[2:1], v.exp[0]);
    end
  endtask

  // Idle cycle (no inputs) with given expected observation
  function automatic vec_t idle(input string nm, input obs_t e);
    return mk(nm, 0, 0, 0, 0, 0, 0, 0, 0, e);
  endfunction

  initial begin
    reset = 1'b1; item_selection_valid = 1'b0; dispense_row = '0; dispense_col = '0;
    item_price = '0; coin_valid = 1'b0; coin_type = '0; cancel = 1'b0;

    // reset
    tbl.push_back(mk("reset", 1, 0,0,0,0, 0,0, 0, ob(0,0,0,0,0,0,0,0,0)));
    tbl.push_back(idle("idle0", ob(0,0,0,0,0,0,0,0,0)));
    // price 250, 100+100+25+25 exact, no change
    tbl.push_back(mk("sel250", 0, 1,3,7,250, 0,0, 0, ob(1,0,0,0,0,0,0,0,0)));
    tbl.push_back(mk("c100a", 0, 0,0,0,0, 1,3, 0, ob(1,100,0,0,0,0,0,0,0)));
    tbl.push_back(mk("c100b", 0, 0,0,0,0, 1,3, 0, ob(1,200,0,0,0,0,0,0,0)));
    tbl.push_back(mk("c25a", 0, 0,0,0,0, 1,2, 0, ob(1,225,0,0,0,0,0,0,0)));
    tbl.push_back(mk("c25b_vend", 0, 0,0,0,0, 1,2, 0, ob(1,250,0,1,3,7,0,0,0)));
    tbl.push_back(idle("done250", ob(0,0,0,0,0,0,0,0,1)));
    // back-to-back selection during change_done cycle; price 175 -> 25 change
    tbl.push_back(mk("sel175", 0, 1,1,2,175, 0,0, 0, ob(1,0,0,0,0,0,0,0,0)));
    tbl.push_back(mk("c100c", 0, 0,0,0,0, 1,3, 0, ob(1,100,0,0,0,0,0,0,0)));
    tbl.push_back(mk("c100d_vend", 0, 0,0,0,0, 1,3, 0, ob(1,200,0,1,1,2,0,0,0)));
    tbl.push_back(idle("chg25", ob(1,0,0,0,0,0,1,2,0)));
    tbl.push_back(idle("done175", ob(0,0,0,0,0,0,0,0,1)));
    // coin in IDLE rejected
    tbl.push_back(mk("idle_coin", 0, 0,0,0,0, 1,1, 0, ob(0,0,1,0,0,0,0,0,0)));
    // price 650, second selection ignored, cancel refunds 25 then 10
    tbl.push_back(mk("sel650", 0, 1,5,9,650, 0,0, 0, ob(1,0,0,0,0,0,0,0,0)));
    tbl.push_back(mk("c25c", 0, 0,0,0,0, 1,2, 0, ob(1,25,0,0,0,0,0,0,0)));
    tbl.push_back(mk("sel_ignored", 0, 1,2,2,5, 1,1, 0, ob(1,35,0,0,0,0,0,0,0)));
    tbl.push_back(mk("cancel", 0, 0,0,0,0, 0,0, 1, ob(1,35,0,0,0,0,0,0,0)));
    tbl.push_back(mk("chg_coin_rej", 0, 0,0,0,0, 1,0, 0, ob(1,10,1,0,0,0,1,2,0)));
    tbl.push_back(idle("chg10", ob(1,0,0,0,0,0,1,1,0)));
    tbl.push_back(idle("done650", ob(0,0,0,0,0,0,0,0,1)));
    // reset in CHANGE with credit 35
    tbl.push_back(mk("sel650b", 0, 1,4,4,650, 0,0, 0, ob(1,0,0,0,0,0,0,0,0)));
    tbl.push_back(mk("c25d", 0, 0,0,0,0, 1,2, 0, ob(1,25,0,0,0,0,0,0,0)));
    tbl.push_back(mk("c10", 0, 0,0,0,0, 1,1, 0, ob(1,35,0,0,0,0,0,0,0)));
    tbl.push_back(mk("cancel_b", 0, 0,0,0,0, 0,0, 1, ob(1,35,0,0,0,0,0,0,0)));
    tbl.push_back(mk("reset_chg", 1, 0,0,0,0, 1,3, 1, ob(0,0,0,0,0,0,0,0,0)));
    tbl.push_back(idle("post_rst1", ob(0,0,0,0,0,0,0,0,0)));
    tbl.push_back(idle("post_rst2", ob(0,0,0,0,0,0,0,0,0)));
    // coin completing price with cancel: coin added, no vend, refunded
    tbl.push_back(mk("sel100", 0, 1,6,1,100, 0,0, 0, ob(1,0,0,0,0,0,0,0,0)));
    tbl.push_back(mk("coin_cancel", 0, 0,0,0,0, 1,3, 1, ob(1,100,0,0,0,0,0,0,0)));
    tbl.push_back(idle("refund100", ob(1,0,0,0,0,0,1,3,0)));
    tbl.push_back(idle("done100", ob(0,0,0,0,0,0,0,0,1)));
    // price 0 vends without a coin
    tbl.push_back(mk("sel0", 0, 1,8,8,0, 0,0, 0, ob(1,0,0,0,0,0,0,0,0)));
    tbl.push_back(idle("vend0", ob(1,0,0,1,8,8,0,0,0)));
    tbl.push_back(idle("done0", ob(0,0,0,0,0,0,0,0,1)));
    // sub-5 remainder forfeited
    tbl.push_back(mk("sel22", 0, 1,0,15,22, 0,0, 0, ob(1,0,0,0,0,0,0,0,0)));
    tbl.push_back(mk("c25_vend22", 0, 0,0,0,0, 1,2, 0, ob(1,25,0,1,0,15,0,0,0)));
    tbl.push_back(idle("done22", ob(0,0,0,0,0,0,0,0,1)));

    foreach (tbl[i]) apply(tbl[i]);

    // Timeout (8 cycles): coin, 8 idle edges, refund on the 9th
    apply(mk("to_sel", 0, 1,2,3,310, 0,0, 0, ob(1,0,0,0,0,0,0,0,0)));
    apply(mk("to_coin", 0, 0,0,0,0, 1,3, 0, ob(1,100,0,0,0,0,0,0,0)));
    for (int i = 0; i < 8; i++) apply(idle("to_wait", ob(1,100,0,0,0,0,0,0,0)));
    apply(idle("to_refund", ob(1,0,0,0,0,0,1,3,0)));
    apply(idle("to_done", ob(0,0,0,0,0,0,0,0,1)));

    // Coin arriving at timer=7 keeps the transaction alive
    apply(mk("to2_sel", 0, 1,2,3,310, 0,0, 0, ob(1,0,0,0,0,0,0,0,0)));
    apply(mk("to2_coin", 0, 0,0,0,0, 1,3, 0, ob(1,100,0,0,0,0,0,0,0)));
    for (int i = 0; i < 7; i++) apply(idle("to2_wait", ob(1,100,0,0,0,0,0,0,0)));
    apply(mk("to2_late_coin", 0, 0,0,0,0, 1,3, 0, ob(1,200,0,0,0,0,0,0,0)));
    for (int i = 0; i < 7; i++) apply(idle("to2_cleared", ob(1,200,0,0,0,0,0,0,0)));
    apply(mk("to2_cancel", 0, 0,0,0,0, 0,0, 1, ob(1,200,0,0,0,0,0,0,0)));
    apply(idle("to2_ref1", ob(1,100,0,0,0,0,1,3,0)));
    apply(idle("to2_ref2", ob(1,0,0,0,0,0,1,3,0)));
    apply(idle("to2_done", ob(0,0,0,0,0,0,0,0,1)));

    // Credit overflow: price 4095, 40x100 = 4000, next 100 rejected, 25 accepted
    apply(mk("ov_sel", 0, 1,9,9,4095, 0,0, 0, ob(1,0,0,0,0,0,0,0,0)));
    for (int i = 1; i <= 40; i++) apply(mk("ov_fill", 0, 0,0,0,0, 1,3, 0, ob(1,100*i,0,0,0,0,0,0,0)));
    apply(mk("ov_reject", 0, 0,0,0,0, 1,3, 0, ob(1,4000,1,0,0,0,0,0,0)));
    apply(mk("ov_c25", 0, 0,0,0,0, 1,2, 0, ob(1,4025,0,0,0,0,0,0,0)));
    apply(mk("ov_cancel", 0, 0,0,0,0, 0,0, 1, ob(1,4025,0,0,0,0,0,0,0)));
    for (int i = 1; i <= 40; i++) apply(idle("ov_ref100", ob(1,4025-100*i,0,0,0,0,1,3,0)));
    apply(idle("ov_ref25", ob(1,0,0,0,0,0,1,2,0)));
    apply(idle("ov_done", ob(0,0,0,0,0,0,0,0,1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
